regfile_arbiter: RTL and testbench
==================================

Name: regfile_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of one RegFile16x8 instance.
- Serialises read and write accesses from two independent clients, for example the digit-scan HLSM and the display readback walker, onto the register file's single R_en/W_en port pair.
- Returns read data with a one-cycle acknowledge per transaction.
- Sits between the client FSMs and RegFile16x8. The register file itself is unchanged.

Parameters:
- ADDR_W, 4, register file address width (16 entries).
- DATA_W, 8, register file data width.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 transaction request. Held until ack0.
- we0  in  1  requester 0 direction: 1 = write, 0 = read.
- addr0  in  ADDR_W  requester 0 address.
- wdata0  in  DATA_W  requester 0 write data.
- ack0  out  1  one-cycle completion pulse to requester 0.
- rdata0  out  DATA_W  requester 0 read result. Valid when ack0=1 and the access was a read; held afterwards.
- req1, we1, addr1, wdata1, ack1, rdata1: same as requester 0, for requester 1.
- rf_raddr  out  ADDR_W  to RegFile16x8 R_Addr.
- rf_waddr  out  ADDR_W  to RegFile16x8 W_Addr.
- rf_ren  out  1  to R_en.
- rf_wen  out  1  to W_en.
- rf_wdata  out  DATA_W  to W_Data.
- rf_rdata  in  DATA_W  from R_Data. Valid the cycle after rf_ren=1.
- busy  out  1  high whenever state is not IDLE.
- gnt_id  out  1  id of the currently or most recently granted requester.

Behaviour:
- Clock and reset: one clock domain. Rst is asynchronous and active-high, as already decided.
- Reset values: all outputs 0. State = IDLE. Last-granted pointer lp = 1, so requester 0 wins the first tie. Internal latches 0.
- Reset asserted mid-transaction aborts it immediately:
  - no ack is issued;
  - rf_ren and rf_wen drop asynchronously;
  - the requester must re-request after reset.
- State machine, Moore outputs, all outputs registered:
  - IDLE:
    - Only req0 high: grant 0. Only req1 high: grant 1. Both high: grant the requester != lp. Neither high: stay in IDLE.
    - On grant: latch id, we, addr and wdata of the winner, set gnt_id = winner, go to ISSUE.
  - ISSUE (exactly 1 cycle):
    - rf_raddr and rf_waddr = latched addr.
    - If we=1: rf_wen=1, rf_wdata = latched wdata, go to ACK.
    - If we=0: rf_ren=1, go to WAIT.
  - WAIT (reads only, 1 cycle): rf_ren=0. Capture rf_rdata into a read-data holding register. Go to ACK.
  - ACK (1 cycle):
    - Pulse ack of the granted id.
    - For a read, update that requester's rdata register (rdata0 or rdata1) from the holding register. The other requester's rdata is unchanged.
    - lp = granted id. Go to IDLE.
- Latency from the req-sampled edge in IDLE to the ack pulse: write = 2 cycles (ISSUE, ACK), read = 3 cycles (ISSUE, WAIT, ACK).
- Peak throughput: one write per 3 cycles, one read per 4 cycles.
- Requester protocol:
  - Hold req, we, addr and wdata stable until ack is seen high.
  - Deassert req on the edge ack is sampled, or keep req high to request again.
  - Req still high in the IDLE after ACK counts as a new request and is arbitrated against the other requester.
- Fairness: with both reqs continuously high, grants alternate 0,1,0,1. Neither requester waits more than one other transaction.
- Request inputs are sampled only in IDLE. Changes to req, we, addr or wdata during ISSUE, WAIT or ACK are ignored.
- rf_wen and rf_ren are never high in the same cycle, and never high outside ISSUE.
- No address range check is needed: ADDR_W=4 covers all 16 entries.

Decomposition:
- Shared package regfile_arb_pkg:
  - state encodings IDLE=0, ISSUE=1, WAIT=2, ACK=3 (2-bit state);
  - ADDR_W and DATA_W defaults.
- Sub-module rr_pick2 (combinational 2-way round-robin selector):
  - inputs req0, req1, lp;
  - outputs any, win_id.
- FSM, latches and rdata registers stay in regfile_arbiter. The bench instantiates the real RegFile16x8 behind it.

Test Plan:
- Write, then read, by requester 0:
  - req0=1, we0=1, addr0=5, wdata0=0x3A -> rf_wen=1 with rf_waddr=5 and rf_wdata=0x3A for exactly 1 cycle; ack0 two cycles after the sample.
  - Then req0 read of addr 5 -> ack0 three cycles after the sample with rdata0=0x3A.
- Cross-requester read: requester 0 writes addr 9 = 0x07, then requester 1 reads addr 9 -> rdata1=0x07 at ack1; rdata0 unchanged.
- Simultaneous requests after reset:
  - req0 and req1 asserted in the same cycle -> requester 0 granted first (gnt_id=0), then requester 1.
  - Both held continuously for 6 transactions -> ack sequence 0,1,0,1,0,1.
- Single requester back-to-back: req1 held high with 4 writes to addr 0..3, data 0x10..0x13 -> acks every 3 cycles; register file contents match.
- Reset mid-read: Rst pulsed during WAIT -> no ack0 or ack1; outputs 0 during reset; after release, requester 1 vs requester 0 tie goes to requester 0.
- Protocol checker over the whole run:
  - rf_ren and rf_wen never both high;
  - each ack is exactly 1 cycle;
  - busy=0 only in IDLE;
  - inputs changed mid-transaction have no effect on rf_raddr, rf_waddr or rf_wdata.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file arbiter: default widths and the
// sequencer state encoding.
package regfile_arb_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/regfile16x8.sv
// 16x8 register file: synchronous write, registered read (R_Data valid the
// cycle after R_en). Contents are not reset.
module RegFile16x8 (
    input  logic       Clk,
    input  logic       W_en,
    input  logic [3:0] W_Addr,
    input  logic [7:0] W_Data,
    input  logic       R_en,
    input  logic [3:0] R_Addr,
    output logic [7:0] R_Data
);

    logic [7:0] mem [16];

    // Write port and registered read port share the same edge.
    always_ff @(posedge Clk) begin
        if (W_en) begin
            mem[W_Addr] <= W_Data;
        end
        if (R_en) begin
            R_Data <= mem[R_Addr];
        end
    end

endmodule

// File: rtl/rr_pick2.sv
// Two-way round-robin selector. On a tie the requester that was not granted
// last (lp) wins; a lone requester always wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic lp,
    output logic any,
    output logic win_id
);

    // Pure combinational pick; no state lives here.
    always_comb begin
        any = req0 | req1;
        if (req0 && req1) begin
            win_id = ~lp;
        end else begin
            win_id = req1;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-client round-robin arbiter/sequencer in front of a single-port-pair
// register file. Each granted access runs ISSUE -> (WAIT) -> ACK, with every
// output taken straight from a flop.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] rf_raddr,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic              rf_ren,
    output logic              rf_wen,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              busy,
    output logic              gnt_id
);

    state_t            state_q,    state_d;
    logic              lp_q,       lp_d;
    logic              id_q,       id_d;
    logic              we_q,       we_d;
    logic              gnt_id_q,   gnt_id_d;
    logic              busy_q,     busy_d;
    logic              ack0_q,     ack0_d;
    logic              ack1_q,     ack1_d;
    logic [DATA_W-1:0] rdata0_q,   rdata0_d;
    logic [DATA_W-1:0] rdata1_q,   rdata1_d;
    logic [ADDR_W-1:0] rf_raddr_q, rf_raddr_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic              rf_ren_q,   rf_ren_d;
    logic              rf_wen_q,   rf_wen_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic              pick_any;
    logic              pick_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .lp     (lp_q),
        .any    (pick_any),
        .win_id (pick_id)
    );

    assign sel_we    = pick_id ? we1    : we0;
    assign sel_addr  = pick_id ? addr1  : addr0;
    assign sel_wdata = pick_id ? wdata1 : wdata0;

    // Next-state and next-output logic. The address/data output registers are
    // loaded once at grant and double as the latched request, so later input
    // changes cannot reach the register file. The winner's rdata register is
    // loaded directly from the register file on WAIT->ACK, so it already holds
    // the read result during the ack pulse.
    always_comb begin
        state_d    = state_q;
        lp_d       = lp_q;
        id_d       = id_q;
        we_d       = we_q;
        gnt_id_d   = gnt_id_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        rf_raddr_d = rf_raddr_q;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rf_ren_d   = 1'b0;
        rf_wen_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    id_d       = pick_id;
                    we_d       = sel_we;
                    gnt_id_d   = pick_id;
                    rf_raddr_d = sel_addr;
                    rf_waddr_d = sel_addr;
                    if (sel_we) begin
                        rf_wen_d   = 1'b1;
                        rf_wdata_d = sel_wdata;
                    end else begin
                        rf_ren_d   = 1'b1;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    ack0_d  = ~id_q;
                    ack1_d  = id_q;
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                ack0_d = ~id_q;
                ack1_d = id_q;
                if (id_q) begin
                    rdata1_d = rf_rdata;
                end else begin
                    rdata0_d = rf_rdata;
                end
                state_d = ST_ACK;
            end
            ST_ACK: begin
                lp_d    = id_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            lp_q       <= 1'b1;
            id_q       <= 1'b0;
            we_q       <= 1'b0;
            gnt_id_q   <= 1'b0;
            busy_q     <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rf_raddr_q <= '0;
            rf_waddr_q <= '0;
            rf_ren_q   <= 1'b0;
            rf_wen_q   <= 1'b0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            lp_q       <= lp_d;
            id_q       <= id_d;
            we_q       <= we_d;
            gnt_id_q   <= gnt_id_d;
            busy_q     <= busy_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            rf_raddr_q <= rf_raddr_d;
            rf_waddr_q <= rf_waddr_d;
            rf_ren_q   <= rf_ren_d;
            rf_wen_q   <= rf_wen_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign rf_raddr = rf_raddr_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_ren   = rf_ren_q;
    assign rf_wen   = rf_wen_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = busy_q;
    assign gnt_id   = gnt_id_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter with the real RegFile16x8 behind it. Stimulus
// pushes the predicted transactions (grant order, direction, address, data,
// read result) into a scoreboard; a negedge monitor checks every register
// file access and every ack against it.
module tb_regfile_arbiter;
    import regfile_arb_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          Clk;
    logic          Rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] rf_raddr, rf_waddr;
    logic          rf_ren, rf_wen;
    logic [DW-1:0] rf_wdata, rf_rdata;
    logic          busy, gnt_id;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    regfile_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk(Clk), .Rst(Rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .rf_raddr(rf_raddr), .rf_waddr(rf_waddr), .rf_ren(rf_ren), .rf_wen(rf_wen),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata), .busy(busy), .gnt_id(gnt_id)
    );

    RegFile16x8 u_rf (
        .Clk(Clk), .W_en(rf_wen), .W_Addr(rf_waddr), .W_Data(rf_wdata),
        .R_en(rf_ren), .R_Addr(rf_raddr), .R_Data(rf_rdata)
    );

    typedef struct {
        int            id;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    typedef struct {
        int            id;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    // Reference model: memory contents, which entries are known, last grant.
    logic [DW-1:0] mem_m [16];
    bit            mem_v [16];
    int            last_m;
    logic [DW-1:0] sh_rd0, sh_rd1;

    txn_t exp_q[$];
    op_t  ops0_q[$];
    op_t  ops1_q[$];
    int   ack_times[$];

    int n_tests;
    int n_fail;
    int cyc_cnt;

    logic ack0_p, ack1_p, wen_p;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc_cnt = 0;
        last_m  = 1;
        sh_rd0  = '0;
        sh_rd1  = '0;
        for (int i = 0; i < 16; i++) mem_v[i] = 1'b0;
    end

    always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Record one transaction in grant order and advance the memory model.
    function automatic void expect_txn(input int id, input bit we,
                                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.id    = id;
        t.we    = we;
        t.addr  = a;
        t.wdata = d;
        t.rdata = mem_m[a];
        if (we) begin
            mem_m[a] = d;
            mem_v[a] = 1'b1;
        end
        exp_q.push_back(t);
        last_m = id;
    endfunction

    // Previous-cycle values for pulse-width checks.
    always @(negedge Clk) begin
        ack0_p <= Rst ? 1'b0 : ack0;
        ack1_p <= Rst ? 1'b0 : ack1;
        wen_p  <= Rst ? 1'b0 : rf_wen;
    end

    // Monitor: protocol rules every cycle, scoreboard on accesses and acks.
    always @(negedge Clk) begin
        txn_t t;
        if (Rst) begin
            sh_rd0 = '0;
            sh_rd1 = '0;
        end else begin
            chk("ren_wen_exclusive", rf_ren & rf_wen, 0);
            chk("ack0_one_cycle", ack0 & ack0_p, 0);
            chk("ack1_one_cycle", ack1 & ack1_p, 0);
            chk("rf_wen_one_cycle", rf_wen & wen_p, 0);
            chk("ack_exclusive", ack0 & ack1, 0);
            chk("activity_implies_busy", (rf_ren | rf_wen | ack0 | ack1) & ~busy, 0);
            if (rf_ren || rf_wen) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rf_access: access with empty scoreboard (t=%0t)", $time);
                end else begin
                    t = exp_q[0];
                    chk("access_dir", rf_wen, t.we);
                    chk("gnt_id_at_issue", gnt_id, t.id);
                    if (rf_wen) begin
                        chk("rf_waddr", rf_waddr, t.addr);
                        chk("rf_wdata", rf_wdata, t.wdata);
                    end else begin
                        chk("rf_raddr", rf_raddr, t.addr);
                    end
                end
            end
            if (ack0 || ack1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ack: ack with empty scoreboard (t=%0t)", $time);
                end else begin
                    t = exp_q.pop_front();
                    chk("ack_id", {ack1, ack0}, (t.id == 0) ? 2'b01 : 2'b10);
                    chk("gnt_id_at_ack", gnt_id, t.id);
                    if (!t.we) begin
                        if (t.id == 0) sh_rd0 = t.rdata;
                        else           sh_rd1 = t.rdata;
                    end
                    chk("rdata0", rdata0, sh_rd0);
                    chk("rdata1", rdata1, sh_rd1);
                    $display("[TB] ack id=%0d we=%0d addr=%0d wdata=0x%02h rdata0=0x%02h rdata1=0x%02h",
                             t.id, t.we, t.addr, t.wdata, rdata0, rdata1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int id, input bit r, input bit w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // Count negedges until the given ack is seen; -1 if it never comes.
    task automatic wait_ack(input int id, output int lat);
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge Clk);
            if ((id == 0 && ack0) || (id == 1 && ack1)) lat = i;
        end
    endtask

    // Single isolated transaction with latency check from the sample edge.
    task automatic do_txn(input int id, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int exp_lat, input string nm);
        int lat;
        set_req(id, 1'b1, w, a, d);
        expect_txn(id, w, a, d);
        @(posedge Clk);
        wait_ack(id, lat);
        chk(nm, lat, exp_lat);
        tick();
        if (id == 0) req0 = 1'b0;
        else         req1 = 1'b0;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        exp_q.delete();
        last_m = 1;
        @(negedge Clk);
        chk("reset_outputs", {ack0, ack1, rdata0, rdata1, rf_raddr, rf_waddr,
                              rf_ren, rf_wen, rf_wdata, busy, gnt_id}, 0);
        tick();
        Rst = 1'b0;
    endtask

    // Both requesters work through their op lists, each re-requesting right
    // after its ack. Grant order is predicted by alternation rules.
    task automatic run_lists();
        int n0, n1, p0, p1, i0, i1, pick, bound;
        bit g0, g1;
        n0 = ops0_q.size();
        n1 = ops1_q.size();
        p0 = 0; p1 = 0; i0 = 0; i1 = 0;
        ack_times.delete();
        while (p0 < n0 || p1 < n1) begin
            if (p0 < n0 && p1 < n1) pick = (last_m == 0) ? 1 : 0;
            else if (p0 < n0)       pick = 0;
            else                    pick = 1;
            if (pick == 0) begin
                expect_txn(0, ops0_q[p0].we, ops0_q[p0].addr, ops0_q[p0].data);
                p0++;
            end else begin
                expect_txn(1, ops1_q[p1].we, ops1_q[p1].addr, ops1_q[p1].data);
                p1++;
            end
        end
        if (n0 > 0) set_req(0, 1'b1, ops0_q[0].we, ops0_q[0].addr, ops0_q[0].data);
        if (n1 > 0) set_req(1, 1'b1, ops1_q[0].we, ops1_q[0].addr, ops1_q[0].data);
        bound = (n0 + n1) * 5 + 10;
        for (int c = 0; c < bound && (i0 < n0 || i1 < n1); c++) begin
            @(negedge Clk);
            g0 = ack0;
            g1 = ack1;
            if (g0 || g1) ack_times.push_back(cyc_cnt);
            tick();
            if (g0 && i0 < n0) begin
                i0++;
                if (i0 < n0) set_req(0, 1'b1, ops0_q[i0].we, ops0_q[i0].addr, ops0_q[i0].data);
                else         req0 = 1'b0;
            end
            if (g1 && i1 < n1) begin
                i1++;
                if (i1 < n1) set_req(1, 1'b1, ops1_q[i1].we, ops1_q[i1].addr, ops1_q[i1].data);
                else         req1 = 1'b0;
            end
        end
        chk("run_complete", (i0 == n0) && (i1 == n1), 1);
        req0 = 1'b0;
        req1 = 1'b0;
        ops0_q.delete();
        ops1_q.delete();
    endtask

    function automatic op_t mk_op(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_t o;
        o.id = 0; o.we = w; o.addr = a; o.data = d;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.id   = 0;
        o.we   = 1'($urandom_range(0, 1));
        o.addr = AW'($urandom_range(0, 15));
        o.data = DW'($urandom_range(0, 255));
        if (!o.we && !mem_v[o.addr]) o.we = 1'b1;
        return o;
    endfunction

    initial begin
        int lat, n0, n1;
        Rst = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge Clk);
        do_reset();
        @(negedge Clk);
        chk("idle_busy_after_reset", busy, 0);

        // Write then read back by requester 0.
        do_txn(0, 1'b1, 4'd5, 8'h3A, 2, "write_latency");
        do_txn(0, 1'b0, 4'd5, 8'h00, 3, "read_latency");

        // Requester 0 writes addr 9 and scrambles its inputs mid-transaction.
        set_req(0, 1'b1, 1'b1, 4'd9, 8'h07);
        expect_txn(0, 1'b1, 4'd9, 8'h07);
        @(posedge Clk);
        #1;
        addr0 = 4'd6; wdata0 = 8'hFF; we0 = 1'b0;
        wait_ack(0, lat);
        chk("scrambled_write_latency", lat, 2);
        tick();
        req0 = 1'b0;
        // Cross-requester read of addr 9.
        do_txn(1, 1'b0, 4'd9, 8'h00, 3, "cross_read_latency");

        // Simultaneous requests after reset: 0 first, then strict alternation.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            ops0_q.push_back(mk_op(1'b1, AW'(10 + k), DW'(8'hA0 + k)));
            ops1_q.push_back(mk_op(k == 2 ? 1'b0 : 1'b1, AW'(13 + (k % 2)), DW'(8'hB0 + k)));
        end
        run_lists();
        chk("alternation_ack_count", ack_times.size(), 6);

        // Back-to-back writes by requester 1: one ack every 3 cycles.
        for (int k = 0; k < 4; k++) ops1_q.push_back(mk_op(1'b1, AW'(k), DW'(8'h10 + k)));
        run_lists();
        chk("b2b_ack_count", ack_times.size(), 4);
        for (int k = 1; k < ack_times.size(); k++)
            chk("b2b_ack_spacing", ack_times[k] - ack_times[k-1], 3);
        for (int k = 0; k < 4; k++) ops0_q.push_back(mk_op(1'b0, AW'(k), 8'h00));
        run_lists();

        // Reset pulsed while a read by requester 1 is in WAIT.
        set_req(1, 1'b1, 1'b0, 4'd9, 8'h00);
        expect_txn(1, 1'b0, 4'd9, 8'h00);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        #1;
        chk("reset_async_outputs", {ack0, ack1, rdata0, rdata1, rf_raddr, rf_waddr,
                                    rf_ren, rf_wen, rf_wdata, busy, gnt_id}, 0);
        req1 = 1'b0;
        exp_q.delete();
        last_m = 1;
        repeat (2) begin
            @(negedge Clk);
            chk("reset_hold_outputs", {ack0, ack1, rf_ren, rf_wen, busy}, 0);
        end
        tick();
        Rst = 1'b0;
        @(negedge Clk);
        chk("no_ack_after_abort", {ack0, ack1, busy}, 0);
        ops0_q.push_back(mk_op(1'b1, 4'd2, 8'h5C));
        ops1_q.push_back(mk_op(1'b0, 4'd9, 8'h00));
        run_lists();

        // Randomized rounds against the model.
        for (int r = 0; r < 40; r++) begin
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 == 0 && n1 == 0) n0 = 1;
            for (int k = 0; k < n0; k++) ops0_q.push_back(rand_op());
            for (int k = 0; k < n1; k++) ops1_q.push_back(rand_op());
            run_lists();
            if ($urandom_range(0, 1) == 1) tick();
        end

        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
